inv_key_expansion: RTL and testbench

- Sequential AES-128 inverse key schedule for the decryption datapath.
- Takes the final round key (round 10) and emits round keys 10, 9, …, 0 in order, one per accepted handshake.
- Feeds the inverse-cipher round logic, which consumes keys in reverse order.
- Recomputes each key on the fly instead of storing all 11 keys.

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/inv_key_step.sv | 24 ++
 rtl/inv_key_expansion.sv | 69 ++++++
 tb/tb_inv_key_expansion.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, types and the byte/word primitives used by the key schedule.
package aes_pkg;

   localparam int BYTE  = 8;
   localparam int WORD  = 32;
   localparam int KEY_W = 128;
   localparam int NR    = 10;

   typedef logic [BYTE-1:0]  byte_t;
   typedef logic [WORD-1:0]  word_t;
   typedef logic [KEY_W-1:0] key_t;
   typedef logic [3:0]       round_t;

   // Forward S-box, entry 0x00 in the top byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic byte_t sbox(input byte_t b);
      return SBOX[{~b, 3'b111} -: 8];
   endfunction

   function automatic byte_t rcon(input round_t i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic word_t sub_word(input word_t w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

endpackage

// File: rtl/inv_key_step.sv
// One inverse AES-128 key-schedule step: round key i -> round key i-1.
// Purely combinational; no handshake.
module inv_key_step
   import aes_pkg::*;
(
   input  logic [KEY_W-1:0] key,
   input  logic [3:0]       roundIdx,
   output logic [KEY_W-1:0] prevKey
);

   word_t a, b, c, d;
   word_t an, bn, cn, dn;

   always_comb begin
      {a, b, c, d} = key;
      dn = d ^ c;
      cn = c ^ b;
      bn = b ^ a;
      // The last word of the previous key is recovered first; it feeds the g() term.
      an = a ^ sub_word(rot_word(dn)) ^ {rcon(roundIdx), 24'h0};
      prevKey = {an, bn, cn, dn};
   end

endmodule

// File: rtl/inv_key_expansion.sv
// Emits AES-128 round keys 10..0 from the round-10 key, one per valid/ready transfer.
// First key one cycle after start; key/index hold while keyReady is low.
module inv_key_expansion
   import aes_pkg::*;
#(
   parameter int NR    = aes_pkg::NR,
   parameter int KEY_W = aes_pkg::KEY_W
)(
   input  logic             clk,
   input  logic             rstN,
   input  logic             start,
   input  logic [KEY_W-1:0] lastKey,
   input  logic             keyReady,
   output logic [KEY_W-1:0] roundKey,
   output logic [3:0]       roundIdx,
   output logic             keyValid,
   output logic             busy,
   output logic             done
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       state;
   logic [KEY_W-1:0] prevKey;

   inv_key_step u_step (
      .key      (roundKey),
      .roundIdx (roundIdx),
      .prevKey  (prevKey)
   );

   // In RUN a key is always on offer, so valid and busy are both the state bit.
   assign busy     = (state == ST_RUN);
   assign keyValid = (state == ST_RUN);

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state    <= ST_IDLE;
         roundKey <= '0;
         roundIdx <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_RUN;
                  roundKey <= lastKey;
                  roundIdx <= 4'(NR);
               end
            end
            ST_RUN: begin
               if (keyReady) begin
                  if (roundIdx == 4'd0) begin
                     state <= ST_IDLE;
                     done  <= 1'b1;
                  end else begin
                     roundKey <= prevKey;
                     roundIdx <= roundIdx - 4'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_key_expansion.sv
// Directed checks of inv_key_expansion against the FIPS-197 AES-128 key schedule.
module tb_inv_key_expansion;

   logic         clk = 1'b0;
   logic         rstN;
   logic         start;
   logic [127:0] lastKey;
   logic         keyReady;
   logic [127:0] roundKey;
   logic [3:0]   roundIdx;
   logic         keyValid;
   logic         busy;
   logic         done;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [127:0] ALT_KEY  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic [127:0] exp_keys [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   inv_key_expansion dut (
      .clk      (clk),
      .rstN     (rstN),
      .start    (start),
      .lastKey  (lastKey),
      .keyReady (keyReady),
      .roundKey (roundKey),
      .roundIdx (roundIdx),
      .keyValid (keyValid),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // {keyValid, busy, done, roundIdx, roundKey}
   function automatic logic [134:0] snap();
      return {keyValid, busy, done, roundIdx, roundKey};
   endfunction

   task automatic chk(input string tag, input logic [134:0] obs, input logic [134:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Runs one expansion of the FIPS-197 key from IDLE; optionally pokes start at
   // round poke_at or resets at round rst_at. Ends on the done cycle (or after reset).
   task automatic run_seq(input string tag, input bit rnd, input int poke_at, input int rst_at);
      int r   = 10;
      int cyc = 0;
      bit fin = 1'b0;
      bit kr;
      lastKey  = exp_keys[10];
      start    = 1'b1;
      keyReady = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!fin && cyc < 300) begin
         chk($sformatf("%s_r%0d", tag, r), snap(), {3'b110, 4'(r), exp_keys[r]});
         if (r == rst_at) begin
            rstN = 1'b0;
            @(negedge clk);
            rstN = 1'b1;
            chk($sformatf("%s_after_reset", tag), snap(), '0);
            @(negedge clk);
            chk($sformatf("%s_no_done", tag), snap(), '0);
            return;
         end
         start = (r == poke_at);
         if (r == poke_at) lastKey = ALT_KEY;
         kr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         keyReady = kr;
         @(negedge clk);
         cyc++;
         if (kr) begin
            if (r == 0) fin = 1'b1;
            else r--;
         end
      end
      start = 1'b0;
      chk($sformatf("%s_completed", tag), 135'(fin), 135'(1));
      if (!rnd) chk($sformatf("%s_len", tag), 135'(cyc), 135'(11));
      chk($sformatf("%s_done", tag), snap(), {3'b001, 4'd0, exp_keys[0]});
   endtask

   initial begin
      rstN     = 1'b0;
      start    = 1'b0;
      keyReady = 1'b0;
      lastKey  = '0;
      repeat (3) @(negedge clk);
      chk("reset", snap(), '0);
      rstN = 1'b1;
      @(negedge clk);
      chk("idle_hold", snap(), '0);

      run_seq("fips", 1'b0, -1, -1);
      @(negedge clk);
      chk("fips_idle", snap(), {3'b000, 4'd0, exp_keys[0]});

      run_seq("backpressure", 1'b1, -1, -1);
      @(negedge clk);
      chk("bp_idle", snap(), {3'b000, 4'd0, exp_keys[0]});

      run_seq("start_busy", 1'b0, 5, -1);
      @(negedge clk);
      chk("busy_idle", snap(), {3'b000, 4'd0, exp_keys[0]});

      run_seq("midreset", 1'b0, -1, 4);

      // Ends on the done cycle; start is raised in that same cycle.
      run_seq("post_reset", 1'b0, -1, -1);
      lastKey  = ZERO_K10;
      start    = 1'b1;
      keyReady = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_first", snap(), {3'b110, 4'd10, ZERO_K10});
      repeat (10) @(negedge clk);
      chk("zero_r0", snap(), {3'b110, 4'd0, 128'h0});
      @(negedge clk);
      chk("zero_done", snap(), {3'b001, 4'd0, 128'h0});
      @(negedge clk);
      chk("zero_idle", snap(), {3'b000, 4'd0, 128'h0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
